// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack for call/ret.
// Define PC_STACK_ERR_EN to build the sticky stack_err misuse flag.
module pc_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_err
);

  localparam int unsigned SpW  = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

  logic [WIDTH-1:0] out_q, out_d;
  logic [SpW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] ret_addr;
  logic [IdxW-1:0]  push_idx, pop_idx;
  logic             push;
  logic             full, empty;

  assign full     = (sp_q == SpW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign ret_addr = out_q + StepW;
  assign push_idx = IdxW'(sp_q);
  assign pop_idx  = IdxW'(sp_q - SpW'(1));

  // Priority: ret > call > load > inc > hold; reset overrides in the registers.
  always_comb begin
    out_d = out_q;
    sp_d  = sp_q;
    push  = 1'b0;
    if (ret) begin
      if (!empty) begin
        out_d = stack_q[pop_idx];
        sp_d  = sp_q - SpW'(1);
      end
    end else if (call) begin
      out_d = in;
      if (!full) begin
        push = 1'b1;
        sp_d = sp_q + SpW'(1);
      end
    end else if (load) begin
      out_d = in;
    end else if (inc) begin
      out_d = ret_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      sp_q  <= '0;
    end else begin
      out_q <= out_d;
      sp_q  <= sp_d;
    end
  end

  // Entries need no reset: anything at or above sp is never read.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack_q[push_idx] <= ret_addr;
    end
  end

`ifdef PC_STACK_ERR_EN
  logic err_q;
  logic err_ev;

  assign err_ev = (ret && empty) || (!ret && call && full);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_ev) begin
      err_q <= 1'b1;
    end
  end

  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

  assign out         = out_q;
  assign sp          = sp_q;
  assign stack_full  = full;
  assign stack_empty = empty;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: vector table, corner sequences, random vs queue model.
module tb_pc_stack;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned STEP  = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] din = '0;
  logic        load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;
  logic [15:0] out;
  logic [3:0]  sp;
  logic        stack_full, stack_empty, stack_err;

  int checks = 0;
  int errors = 0;

  // Reference model: pc value plus a queue of return addresses.
  int unsigned mpc = 0;
  logic [15:0] mq[$];
  bit          merr = 1'b0;

  pc_stack #(.WIDTH(16), .DEPTH(DEPTH), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .in(din), .load(load), .inc(inc), .call(call), .ret(ret),
    .out(out), .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input bit r, input bit ld, input bit ic, input bit cl,
                                input bit rt, input logic [15:0] d);
    if (r) begin
      mpc = 0;
      mq.delete();
      merr = 1'b0;
    end else if (rt) begin
      if (mq.size() != 0) mpc = mq.pop_back();
      else merr = 1'b1;
    end else if (cl) begin
      if (mq.size() < DEPTH) mq.push_back(16'((mpc + STEP) % 65536));
      else merr = 1'b1;
      mpc = d;
    end else if (ld) begin
      mpc = d;
    end else if (ic) begin
      mpc = (mpc + STEP) % 65536;
    end
  endfunction

  // Drive one cycle from the falling edge, sample at the next falling edge.
  task automatic step(input bit r, input bit ld, input bit ic, input bit cl, input bit rt,
                      input logic [15:0] d);
    logic [15:0] prev;
    prev  = out;
    reset = r; load = ld; inc = ic; call = cl; ret = rt; din = d;
    #1;
    check("no_comb_path", out, prev);
    @(posedge clk);
    @(negedge clk);
    model(r, ld, ic, cl, rt, d);
    check("out", out, mpc[15:0]);
    check("sp", sp, mq.size());
    check("full", stack_full, mq.size() == DEPTH);
    check("empty", stack_empty, mq.size() == 0);
`ifdef PC_STACK_ERR_EN
    check("err", stack_err, merr);
`else
    check("err", stack_err, 1'b0);
`endif
  endtask

  typedef struct {
    logic r, ld, ic, cl, rt;
    logic [15:0] din;
    logic [15:0] eout;
    logic [3:0]  esp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 4'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0002, 4'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0003, 4'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0010, 4'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0100, 4'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0101, 4'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0102, 4'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0011, 4'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234, 4'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0050, 16'h0050, 4'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0777, 16'h1235, 4'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0999, 16'h1235, 4'd0};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].ld, tbl[i].ic, tbl[i].cl, tbl[i].rt, tbl[i].din);
      check($sformatf("tbl%0d_out", i), out, tbl[i].eout);
      check($sformatf("tbl%0d_sp", i), sp, tbl[i].esp);
    end

    // Fill to overflow, then unwind in LIFO order and underflow once.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'(16'h0200 + i));
    check("fill_out", out, 16'h0208);
    check("fill_sp", sp, 4'd8);
    check("fill_full", stack_full, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      check($sformatf("pop%0d", k), out, (k < 7) ? 16'(16'h0207 - k) : 16'h0001);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("underflow_hold", out, 16'h0001);
`ifdef PC_STACK_ERR_EN
    check("underflow_err", stack_err, 1'b1);
`else
    check("underflow_err", stack_err, 1'b0);
`endif

    // Wraparound on inc and on the pushed return address.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check("wrap_inc", out, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0300);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("wrap_push", out, 16'h0000);

    // Reset beats a concurrent call and discards the stack.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'(16'h0400 + i));
    check("pre_reset_sp", sp, 4'd3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0500);
    check("rst_out", out, 16'h0000);
    check("rst_sp", sp, 4'd0);
    check("rst_err", stack_err, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("rst_ret_hold", out, 16'h0000);

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
